// File: rtl/filter_frame_ctrl.sv
// ---------------------------------------------------------------------------
// filter_frame_ctrl
//
// Frame sequencer for the 3x3 operation-window filter pipeline. A start
// command clears the window/operation stages with a one-cycle refresh pulse.
// It then reads the image row-major from pixel memory and streams tagged
// pixel words into the window generator. After the last pixel it sends an
// end-of-frame word and waits for that tag to come back out of the operation
// stage. Results seen on the way are counted. Completion is signalled with a
// done pulse, or with a sticky timeout error if the end tag never returns.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         begin a frame (only honoured while idle)
//   base_addr     address of pixel (0,0), latched at start
//   img_width     pixels per line, latched at start
//   img_height    lines per frame, latched at start
//   busy          high whenever the sequencer is not idle
//   done          one-cycle completion pulse
//   timeout_err   sticky drain timeout flag, cleared by an accepted start
//   rd_req        pixel memory read request
//   rd_addr       pixel memory read address
//   rd_ack        read transfer happens this cycle
//   rd_data       read pixel, valid with rd_ack
//   refresh       pipeline clear pulse to window/operation stages
//   pix_out       tagged word into the window generator, every cycle
//   res_in        tagged word from the operation stage
//   result_cnt    number of result words seen during the current frame
// ---------------------------------------------------------------------------
module filter_frame_ctrl #(
  parameter int                   TAG_WIDTH    = 2,
  parameter logic [TAG_WIDTH-1:0] INVALID_TAG  = 2'd0,
  parameter logic [TAG_WIDTH-1:0] DATA_TAG0    = 2'd1,
  parameter logic [TAG_WIDTH-1:0] DATA_TAG1    = 2'd2,
  parameter logic [TAG_WIDTH-1:0] DATA_END_TAG = 2'd3,
  parameter int                   DATA_WIDTH   = 8 + TAG_WIDTH,
  parameter int                   DIM_WIDTH    = 10,
  parameter int                   ADDR_WIDTH   = 20,
  parameter int                   TIMEOUT      = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [DIM_WIDTH-1:0]   img_width,
  input  logic [DIM_WIDTH-1:0]   img_height,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic                   rd_req,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic                   rd_ack,
  input  logic [7:0]             rd_data,
  output logic                   refresh,
  output logic [DATA_WIDTH-1:0]  pix_out,
  input  logic [DATA_WIDTH-1:0]  res_in,
  output logic [2*DIM_WIDTH-1:0] result_cnt
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [DIM_WIDTH-1:0]   DIM_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [2*DIM_WIDTH-1:0] RES_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0]  FILLER   = {INVALID_TAG, 8'h00};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REFRESH,
    ST_FETCH,
    ST_END,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [DIM_WIDTH-1:0]   width_q, width_d;
  logic [DIM_WIDTH-1:0]   height_q, height_d;
  logic [DIM_WIDTH-1:0]   x_q, x_d;
  logic [DIM_WIDTH-1:0]   y_q, y_d;
  logic [CNT_WIDTH-1:0]   drain_q, drain_d;
  logic [2*DIM_WIDTH-1:0] result_cnt_q, result_cnt_d;
  logic [DATA_WIDTH-1:0]  pix_q, pix_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic                   rd_req_q, rd_req_d;
  logic                   refresh_q, refresh_d;

  logic [TAG_WIDTH-1:0]   res_tag;
  logic                   res_is_data;
  logic                   last_col;
  logic                   res_pix_unused;

  // Only the tag of the operation output matters here; the pixel is ignored.
  assign res_tag        = res_in[8 +: TAG_WIDTH];
  assign res_is_data    = (res_tag == DATA_TAG0) || (res_tag == DATA_TAG1);
  assign res_pix_unused = ^res_in[7:0];
  assign last_col       = (x_q == width_q - DIM_ONE);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_addr_q    <= '0;
      width_q      <= '0;
      height_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      drain_q      <= '0;
      result_cnt_q <= '0;
      pix_q        <= FILLER;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      rd_req_q     <= 1'b0;
      refresh_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      width_q      <= width_d;
      height_q     <= height_d;
      x_q          <= x_d;
      y_q          <= y_d;
      drain_q      <= drain_d;
      result_cnt_q <= result_cnt_d;
      pix_q        <= pix_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      rd_req_q     <= rd_req_d;
      refresh_q    <= refresh_d;
    end
  end

  // Next-state logic. Every output register is loaded from the next state,
  // so busy/refresh/rd_req/done line up with the state they describe, and
  // pix_out carries the word produced by the previous cycle's transfer.
  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    width_d      = width_q;
    height_d     = height_q;
    x_d          = x_q;
    y_d          = y_q;
    drain_d      = drain_q;
    result_cnt_d = result_cnt_q;
    timeout_d    = timeout_q;
    pix_d        = FILLER;

    if (state_q != ST_IDLE && res_is_data) begin
      result_cnt_d = result_cnt_q + RES_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_REFRESH;
          rd_addr_d    = base_addr;
          width_d      = img_width;
          height_d     = img_height;
          x_d          = '0;
          y_d          = '0;
          result_cnt_d = '0;
          timeout_d    = 1'b0;
        end
      end
      ST_REFRESH: begin
        // An empty image skips reading entirely but still sends the end word.
        if (width_q != '0 && height_q != '0) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_END;
        end
      end
      ST_FETCH: begin
        // rd_req is high throughout FETCH, so rd_ack alone marks a transfer.
        if (rd_ack) begin
          pix_d     = {(last_col ? DATA_TAG1 : DATA_TAG0), rd_data};
          rd_addr_d = rd_addr_q + ADDR_ONE;
          if (last_col) begin
            x_d = '0;
            y_d = y_q + DIM_ONE;
            if (y_q == height_q - DIM_ONE) begin
              state_d = ST_END;
            end
          end else begin
            x_d = x_q + DIM_ONE;
          end
        end
      end
      ST_END: begin
        pix_d   = {DATA_END_TAG, 8'h00};
        drain_d = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Returning end tag wins over a timeout expiring in the same cycle.
        if (res_tag == DATA_END_TAG) begin
          state_d = ST_DONE;
        end else if (drain_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          drain_d = drain_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d    = (state_d != ST_IDLE);
  assign refresh_d = (state_d == ST_REFRESH);
  assign rd_req_d  = (state_d == ST_FETCH);
  assign done_d    = (state_d == ST_DONE);

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_q;
  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign refresh     = refresh_q;
  assign pix_out     = pix_q;
  assign result_cnt  = result_cnt_q;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_filter_frame_ctrl
//
// Drives whole frames through filter_frame_ctrl with random pixel data and
// random read-acknowledge patterns. The operation stage is modelled as a
// three-cycle echo of pix_out, or is held silent to force a timeout. The
// expected read addresses, pixel words, end word, result count and
// completion timing are derived from the frame geometry. They are not
// derived from the controller's internals.
// ---------------------------------------------------------------------------
module tb_filter_frame_ctrl;

  localparam int AW           = 20;
  localparam int DIMW         = 10;
  localparam int DW           = 10;
  localparam int TMO          = 16;
  localparam int FRAME_BUDGET = 2000;
  localparam int ECHO_DONE    = 4;

  localparam logic [1:0]    TAG_INV = 2'd0;
  localparam logic [1:0]    TAG0    = 2'd1;
  localparam logic [1:0]    TAG1    = 2'd2;
  localparam logic [1:0]    TAG_END = 2'd3;
  localparam logic [DW-1:0] INV     = {TAG_INV, 8'h00};
  localparam logic [DW-1:0] ENDW    = {TAG_END, 8'h00};

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [DIMW-1:0]   img_width;
  logic [DIMW-1:0]   img_height;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic              rd_ack;
  logic [7:0]        rd_data;
  logic              refresh;
  logic [DW-1:0]     pix_out;
  logic [DW-1:0]     res_in;
  logic [2*DIMW-1:0] result_cnt;

  logic [DW-1:0]     echoLine [0:2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  filter_frame_ctrl #(
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .img_width  (img_width),
    .img_height (img_height),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .refresh    (refresh),
    .pix_out    (pix_out),
    .res_in     (res_in),
    .result_cnt (result_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Data tags on res_in while idle must not move result_cnt.
  task automatic idleJunk();
    logic [2*DIMW-1:0] held;
    held = result_cnt;
    repeat (3) begin
      res_in = {($urandom_range(0, 1) == 1) ? TAG1 : TAG0, 8'($urandom)};
      @(negedge clk);
    end
    res_in = INV;
    checkOutput("idle_result_hold", result_cnt, held);
    checkOutput("idle_busy_low", busy, 0);
  endtask

  // Runs one frame starting at the current negedge.
  // ackMode: 0 ack always, 1 ack every other cycle, 2 random ack.
  // abortAt: if nonzero, assert rst in the cycle of that read transfer.
  task automatic applyStimulus(input logic [AW-1:0] base, input int w, input int h,
                               input int ackMode, input bit echo, input bit injectEnd,
                               input bit injectStart, input int abortAt, input bit startOnDone);
    logic [DW-1:0] expWord;
    logic [DW-1:0] stream[$];
    logic [AW-1:0] ea;
    int nXfer, refCnt, reqAfter, expRes, endCycle, doneCycle;
    bit prevXfer, prevStall, seenEnd, alt, startPulsed, ack, aborted;
    nXfer = 0; refCnt = 0; reqAfter = 0; expRes = 0; endCycle = -1; doneCycle = -1;
    prevXfer = 0; prevStall = 0; seenEnd = 0; alt = 0; startPulsed = 0; aborted = 0;
    expWord = INV;
    stream.delete();

    base_addr  = base;
    img_width  = DIMW'(w);
    img_height = DIMW'(h);
    start      = 1'b1;
    rd_ack     = 1'b0;
    res_in     = INV;
    for (int i = 0; i < 3; i++) echoLine[i] = INV;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("timeout_err_cleared", timeout_err, 0);
    checkOutput("result_cnt_cleared", result_cnt, 0);

    for (int cyc = 0; cyc < FRAME_BUDGET; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;

      if (refresh) refCnt++;
      if (prevXfer) checkOutput("pix_data", pix_out, expWord);
      else if (prevStall) checkOutput("pix_stall_filler", pix_out, INV);
      if (pix_out[9:8] != TAG_INV) stream.push_back(pix_out);
      if (pix_out == ENDW && !seenEnd) begin
        seenEnd  = 1;
        endCycle = cyc;
      end
      prevXfer  = 0;
      prevStall = 0;

      rd_data = 8'($urandom);
      if (rd_req) begin
        if (nXfer >= w * h) reqAfter++;
        ea = base + AW'(nXfer);
        checkOutput("rd_addr", rd_addr, ea);
        case (ackMode)
          0:       ack = 1'b1;
          1:       begin ack = alt; alt = !alt; end
          default: ack = 1'($urandom_range(0, 1));
        endcase
        rd_ack = ack;
        if (ack) begin
          expWord  = {((w > 0) && ((nXfer % w) == (w - 1))) ? TAG1 : TAG0, rd_data};
          nXfer++;
          prevXfer = 1;
          if (nXfer == abortAt) begin
            rst     = 1'b1;
            aborted = 1;
            break;
          end
        end else begin
          prevStall = 1;
        end
      end else begin
        rd_ack = 1'($urandom_range(0, 1));
      end

      if (injectStart && !startPulsed && nXfer == 1) begin
        start       = 1'b1;
        base_addr   = base ^ 20'h5A5A5;
        img_width   = DIMW'(w + 2);
        img_height  = DIMW'(h + 1);
        startPulsed = 1;
      end

      res_in      = echo ? echoLine[2] : INV;
      echoLine[2] = echoLine[1];
      echoLine[1] = echoLine[0];
      echoLine[0] = pix_out;
      if (injectEnd && !seenEnd && res_in[9:8] == TAG_INV && $urandom_range(0, 3) == 0)
        res_in = {TAG_END, 8'hA5};
      if (res_in[9:8] == TAG0 || res_in[9:8] == TAG1) expRes++;

      if (done) begin
        doneCycle = cyc;
        if (startOnDone) begin
          start      = 1'b1;
          base_addr  = 20'hABCDE;
          img_width  = 10'd7;
          img_height = 10'd7;
        end
        break;
      end
    end

    if (aborted) begin
      @(negedge clk);
      rst    = 1'b0;
      rd_ack = 1'b0;
      res_in = INV;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_timeout_err", timeout_err, 0);
      checkOutput("abort_rd_req", rd_req, 0);
      checkOutput("abort_refresh", refresh, 0);
      checkOutput("abort_rd_addr", rd_addr, 0);
      checkOutput("abort_result_cnt", result_cnt, 0);
      checkOutput("abort_pix_out", pix_out, INV);
      repeat (4) begin
        @(negedge clk);
        checkOutput("abort_no_done", done, 0);
      end
      return;
    end

    checkOutput("frame_done_seen", doneCycle >= 0, 1);
    checkOutput("xfer_count", nXfer, w * h);
    checkOutput("req_after_last", reqAfter, 0);
    checkOutput("refresh_pulses", refCnt, 1);
    checkOutput("stream_len", stream.size(), w * h + 1);
    if (stream.size() > 0) checkOutput("end_word_last", stream[$], ENDW);
    checkOutput("done_latency", doneCycle - endCycle, echo ? ECHO_DONE : TMO);
    checkOutput("timeout_err_at_done", timeout_err, !echo);

    @(negedge clk);
    start  = 1'b0;
    rd_ack = 1'b0;
    res_in = INV;
    checkOutput("done_one_cycle", done, 0);
    checkOutput("idle_after_done", busy, 0);
    checkOutput("result_cnt", result_cnt, expRes);
    checkOutput("timeout_err_hold", timeout_err, !echo);
    if (!startOnDone) idleJunk();
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    img_width  = '0;
    img_height = '0;
    rd_ack     = 1'b0;
    rd_data    = '0;
    res_in     = INV;
    for (int i = 0; i < 3; i++) echoLine[i] = INV;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_timeout_err", timeout_err, 0);
    checkOutput("reset_rd_req", rd_req, 0);
    checkOutput("reset_refresh", refresh, 0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_result_cnt", result_cnt, 0);
    checkOutput("reset_pix_out", pix_out, INV);
    rst = 1'b0;
    idleJunk();

    $display("[TB] 4x2 frame, ack tied high");
    applyStimulus(20'h00100, 4, 2, 0, 1, 0, 0, 0, 0);
    $display("[TB] 4x2 frame, ack every other cycle");
    applyStimulus(20'h00100, 4, 2, 1, 1, 0, 0, 0, 0);
    $display("[TB] empty frame 0x5");
    applyStimulus(20'h00040, 0, 5, 0, 1, 0, 0, 0, 0);
    $display("[TB] silent operation stage, drain timeout");
    applyStimulus(20'h00200, 4, 2, 0, 0, 0, 0, 0, 0);
    $display("[TB] start during fetch and on done, stray end tags");
    applyStimulus(20'h00300, 3, 3, 2, 1, 1, 1, 0, 1);
    $display("[TB] start one cycle after done");
    applyStimulus(20'h00400, 2, 3, 2, 1, 1, 0, 0, 0);
    $display("[TB] reset at third transfer");
    applyStimulus(20'h00500, 5, 2, 0, 1, 0, 0, 3, 0);
    $display("[TB] clean frame after reset");
    applyStimulus(20'h00500, 5, 2, 0, 1, 0, 0, 0, 0);
    for (int f = 0; f < 5; f++) begin
      $display("[TB] random frame %0d", f);
      applyStimulus(AW'($urandom), $urandom_range(1, 6), $urandom_range(1, 4),
                    $urandom_range(0, 2), 1, 1, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
